fir_uart_seq: RTL and testbench
===============================

// Module: fir_uart_seq
// PURPOSE
//  Top-level sequencer for the UART -> FIR -> UART loop. Assembles DW-bit samples from
//  MSB-first UART bytes, drives FIR_in and pulses FIR_strt, then waits for FIR_valid.
//  Serialises the captured FIR result back out through the UART transmitter, MSB first,
//  using the TxD_busy handshake. Sits between the uart rx/tx cores and the FIR datapath.
// PARAMETERS
//  DW              16     sample width to FIR; fixed 2 bytes (MSB then LSB)
//  OW              16     FIR result width; multiple of 8, 8..32; OW/8 bytes sent
//  TIMEOUT_CYCLES  50000  inter-byte gap limit (used only with RX_TIMEOUT_EN)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  RxD_ready   in   1   one-cycle pulse: RxD_data valid
//  RxD_data    in   8   received byte
//  TxD_busy    in   1   transmitter busy; start only accepted while low
//  TxD_start   out  1   one-cycle pulse: send TxD_data
//  TxD_data    out  8   byte to transmit, stable from start until TxD_busy falls
//  FIR_in      out  DW  assembled sample, stable from FIR_strt until next MSB capture
//  FIR_strt    out  1   one-cycle pulse: FIR_in valid
//  FIR_valid   in   1   one-cycle pulse: FIR_out valid
//  FIR_out     in   OW  FIR result
//  seq_busy    out  1   high in every state except S_IDLE
//  overrun     out  1   sticky: byte arrived while not accepting; cleared only by rst
//  rx_timeout  out  1   one-cycle pulse on inter-byte timeout (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state S_IDLE; all outputs 0 (TxD_data, FIR_in = 0). Reset mid-operation
//    abandons the sample/result; an in-flight UART byte is not aborted here.
//  - All outputs registered. FSM states and transitions:
//    S_IDLE:     RxD_ready -> FIR_in[15:8]<=RxD_data, go S_WAIT_LSB
//    S_WAIT_LSB: RxD_ready -> FIR_in[7:0]<=RxD_data, go S_FIR_STRT
//    S_FIR_STRT: FIR_strt=1 this cycle only, go S_FIR_WAIT (LSB edge -> FIR_strt: 1 clk)
//    S_FIR_WAIT: FIR_valid -> shift reg<=FIR_out, byte count<=OW/8-1, go S_TX_SEND
//    S_TX_SEND:  if !TxD_busy: TxD_data<=top byte, TxD_start=1 (1 cycle), go S_TX_GUARD
//    S_TX_GUARD: one cycle, TxD_busy ignored (covers tx busy-rise latency), go S_TX_DRAIN
//    S_TX_DRAIN: wait !TxD_busy; count==0 -> S_IDLE, else shift left 8, count--, S_TX_SEND
//  - FIR_valid outside S_FIR_WAIT ignored. No FIR timeout: FIR must answer.
//  - RxD_ready in any state other than S_IDLE/S_WAIT_LSB: byte dropped, overrun<=1.
//  - RxD_ready and FSM exit on same edge (e.g. S_TX_DRAIN -> S_IDLE): byte dropped,
//    overrun set; acceptance is decided by the current state only.
//  - Byte order out: FIR_out[OW-1:OW-8] first, FIR_out[7:0] last.
// CONFIGURATION
//  RX_TIMEOUT_EN defined: counter clears on entry to S_WAIT_LSB, increments each cycle
//    there; on reaching TIMEOUT_CYCLES-1 without RxD_ready -> S_IDLE, MSB discarded,
//    rx_timeout pulses 1 cycle. RxD_ready on the terminal cycle wins (byte accepted).
//  RX_TIMEOUT_EN undefined: no counter; S_WAIT_LSB waits forever; rx_timeout tied 0.
// STRUCTURE
//  - Package fir_uart_pkg: state encoding typedef (3-bit), BYTE_W=8, SAMPLE_BYTES=2.
//  - One sub-module tx_byte_seq: S_TX_SEND/GUARD/DRAIN + result shift reg + byte count;
//    started by a load pulse from the top FSM, returns done pulse.
// TESTING
//  1. rst, RxD bytes 0x12 then 0x34 -> FIR_in=0x1234, FIR_strt 1 clk after 2nd ready.
//  2. FIR_valid with FIR_out=0xABCD, TxD_busy idle model (busy 10 clk after start) ->
//     TxD_start twice, TxD_data 0xAB then 0xCD, second start only after busy falls.
//  3. OW=24, FIR_out=0x0102A5 -> three bytes 0x01,0x02,0xA5; seq_busy low after last.
//  4. RxD_ready during S_FIR_WAIT -> byte dropped, overrun=1 until rst, sample intact.
//  5. RX_TIMEOUT_EN, TIMEOUT_CYCLES=8: single byte then silence -> rx_timeout pulse,
//     S_IDLE; next 0x55,0x66 -> FIR_in=0x5566. Also ready on terminal cycle accepted.
//  6. rst asserted in S_TX_DRAIN -> next clk all outputs 0, S_IDLE, no further TxD_start.

Source files
------------

// File: rtl/fir_uart_pkg.sv
// Shared types for the UART -> FIR -> UART sequencer: state encoding and byte sizes.
package fir_uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int SAMPLE_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_LSB = 3'd1,
    S_FIR_STRT = 3'd2,
    S_FIR_WAIT = 3'd3,
    S_TX_SEND  = 3'd4,
    S_TX_GUARD = 3'd5,
    S_TX_DRAIN = 3'd6
  } state_t;

endpackage

// File: rtl/fir_uart_seq_tx_byte_seq.sv
// Serialises an OW-bit FIR result MSB-first through the UART transmitter using the
// TxD_busy handshake; loaded by a one-cycle pulse, reports completion with a done pulse.
module tx_byte_seq
  import fir_uart_pkg::*;
#(
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [OW-1:0] result,
  input  logic          txd_busy,
  output logic          txd_start,
  output logic [7:0]    txd_data,
  output logic          done
);

  localparam int NB = OW / BYTE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  state_t        state_q, state_d;
  logic [OW-1:0] shift_q, shift_d;
  logic [CW-1:0] count_q, count_d;
  logic          txd_start_q, txd_start_d;
  logic [7:0]    txd_data_q, txd_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      txd_start_q <= 1'b0;
      txd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      txd_start_q <= txd_start_d;
      txd_data_q  <= txd_data_d;
    end
  end

  // The guard cycle hides the transmitter's one-cycle delay in raising busy after a start.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    txd_start_d = 1'b0;
    txd_data_d  = txd_data_q;
    done        = 1'b0;
    case (state_q)
      S_TX_SEND: begin
        if (!txd_busy) begin
          txd_data_d  = shift_q[OW-1 -: BYTE_W];
          txd_start_d = 1'b1;
          state_d     = S_TX_GUARD;
        end
      end
      S_TX_GUARD: state_d = S_TX_DRAIN;
      S_TX_DRAIN: begin
        if (!txd_busy) begin
          if (count_q == '0) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            shift_d = shift_q << BYTE_W;
            count_d = count_q - CW'(1);
            state_d = S_TX_SEND;
          end
        end
      end
      default: begin
        if (load) begin
          shift_d = result;
          count_d = CW'(NB - 1);
          state_d = S_TX_SEND;
        end
      end
    endcase
  end

  assign txd_start = txd_start_q;
  assign txd_data  = txd_data_q;

endmodule

// File: rtl/fir_uart_seq.sv
// Top sequencer: builds 16-bit samples from two UART bytes, kicks the FIR, then streams
// the result back out. Optional macro RX_TIMEOUT_EN adds an inter-byte timeout.
module fir_uart_seq
  import fir_uart_pkg::*;
#(
  parameter int DW             = 16,
  parameter int OW             = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RxD_ready,
  input  logic [7:0]    RxD_data,
  input  logic          TxD_busy,
  output logic          TxD_start,
  output logic [7:0]    TxD_data,
  output logic [DW-1:0] FIR_in,
  output logic          FIR_strt,
  input  logic          FIR_valid,
  input  logic [OW-1:0] FIR_out,
  output logic          seq_busy,
  output logic          overrun,
  output logic          rx_timeout
);

  state_t        state_q, state_d;
  logic [DW-1:0] fir_in_q, fir_in_d;
  logic          fir_strt_q, fir_strt_d;
  logic          seq_busy_q, seq_busy_d;
  logic          overrun_q, overrun_d;
  logic          tx_load;
  logic          tx_done;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rx_timeout_q, rx_timeout_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fir_in_q   <= '0;
      fir_strt_q <= 1'b0;
      seq_busy_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      rx_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fir_in_q   <= fir_in_d;
      fir_strt_q <= fir_strt_d;
      seq_busy_q <= seq_busy_d;
      overrun_q  <= overrun_d;
`ifdef RX_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      rx_timeout_q <= rx_timeout_d;
`endif
    end
  end

  // S_TX_SEND stands for the whole transmit phase here; the sub-sequencer owns its steps.
  always_comb begin
    state_d    = state_q;
    fir_in_d   = fir_in_q;
    fir_strt_d = 1'b0;
    tx_load    = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    rx_timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (RxD_ready) begin
          fir_in_d[DW-1 -: BYTE_W] = RxD_data;
          state_d                  = S_WAIT_LSB;
`ifdef RX_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_WAIT_LSB: begin
        if (RxD_ready) begin
          fir_in_d[BYTE_W-1:0] = RxD_data;
          fir_strt_d           = 1'b1;
          state_d              = S_FIR_STRT;
        end
`ifdef RX_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_FIR_STRT: state_d = S_FIR_WAIT;
      S_FIR_WAIT: begin
        if (FIR_valid) begin
          tx_load = 1'b1;
          state_d = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    seq_busy_d = (state_d != S_IDLE);
    overrun_d  = overrun_q |
                 (RxD_ready && (state_q != S_IDLE) && (state_q != S_WAIT_LSB));
  end

  tx_byte_seq #(.OW(OW)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .result    (FIR_out),
    .txd_busy  (TxD_busy),
    .txd_start (TxD_start),
    .txd_data  (TxD_data),
    .done      (tx_done)
  );

  assign FIR_in   = fir_in_q;
  assign FIR_strt = fir_strt_q;
  assign seq_busy = seq_busy_q;
  assign overrun  = overrun_q;
`ifdef RX_TIMEOUT_EN
  assign rx_timeout = rx_timeout_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fir_uart_seq.sv
// Self-checking bench: two sequencers (OW=16 and OW=24) fed the same random samples,
// each with its own UART busy model, checked against a byte-queue reference model.
module tb_fir_uart_seq;

`ifdef RX_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 50000;
`endif
  localparam int BUSY_LEN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        RxD_ready;
  logic [7:0]  RxD_data;
  logic        FIR_valid;
  logic [15:0] FIR_out16;
  logic [23:0] FIR_out24;

  logic        busy16, start16, strt16, sbusy16, ovr16, tmo16;
  logic [7:0]  data16;
  logic [15:0] fin16;
  logic        busy24, start24, strt24, sbusy24, ovr24, tmo24;
  logic [7:0]  data24;
  logic [15:0] fin24;

  int busy_cnt16 = 0;
  int busy_cnt24 = 0;
  int assertions = 0;
  int failures   = 0;

  logic [7:0] got16[$], got24[$], exp16[$], exp24[$];

  always #5 clk = ~clk;

  fir_uart_seq #(.DW(16), .OW(16), .TIMEOUT_CYCLES(TMO)) u_dut16 (
    .clk(clk), .rst(rst), .RxD_ready(RxD_ready), .RxD_data(RxD_data),
    .TxD_busy(busy16), .TxD_start(start16), .TxD_data(data16),
    .FIR_in(fin16), .FIR_strt(strt16), .FIR_valid(FIR_valid), .FIR_out(FIR_out16),
    .seq_busy(sbusy16), .overrun(ovr16), .rx_timeout(tmo16)
  );

  fir_uart_seq #(.DW(16), .OW(24), .TIMEOUT_CYCLES(TMO)) u_dut24 (
    .clk(clk), .rst(rst), .RxD_ready(RxD_ready), .RxD_data(RxD_data),
    .TxD_busy(busy24), .TxD_start(start24), .TxD_data(data24),
    .FIR_in(fin24), .FIR_strt(strt24), .FIR_valid(FIR_valid), .FIR_out(FIR_out24),
    .seq_busy(sbusy24), .overrun(ovr24), .rx_timeout(tmo24)
  );

  // UART transmitter stand-in: busy rises the cycle after a start and lasts BUSY_LEN clocks
  always @(posedge clk) begin
    if (start16) busy_cnt16 <= BUSY_LEN;
    else if (busy_cnt16 > 0) busy_cnt16 <= busy_cnt16 - 1;
    if (start24) busy_cnt24 <= BUSY_LEN;
    else if (busy_cnt24 > 0) busy_cnt24 <= busy_cnt24 - 1;
  end
  assign busy16 = (busy_cnt16 != 0);
  assign busy24 = (busy_cnt24 != 0);

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Capture every transmitted byte; a start is only legal while the transmitter is idle
  always @(negedge clk) begin
    if (start16) begin
      got16.push_back(data16);
      check_output("start16_while_idle", {31'b0, busy16}, 32'd0);
    end
    if (start24) begin
      got24.push_back(data24);
      check_output("start24_while_idle", {31'b0, busy24}, 32'd0);
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    RxD_data  = b;
    RxD_ready = 1'b1;
    @(negedge clk);
    RxD_ready = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] msb, input logic [7:0] lsb, input int gap);
    rx_byte(msb);
    check_output("busy_after_msb", {31'b0, sbusy16}, 32'd1);
    repeat (gap) @(negedge clk);
    rx_byte(lsb);
    check_output("fir_strt16", {31'b0, strt16}, 32'd1);
    check_output("fir_strt24", {31'b0, strt24}, 32'd1);
    check_output("fir_in16", {16'b0, fin16}, {16'b0, msb, lsb});
    check_output("fir_in24", {16'b0, fin24}, {16'b0, msb, lsb});
    @(negedge clk);
    check_output("fir_strt_one_cycle", {31'b0, strt16 | strt24}, 32'd0);
  endtask

  task automatic fir_reply(input logic [15:0] r16, input logic [23:0] r24, input int delay);
    repeat (delay) @(negedge clk);
    FIR_out16 = r16;
    FIR_out24 = r24;
    FIR_valid = 1'b1;
    @(negedge clk);
    FIR_valid = 1'b0;
    FIR_out16 = 16'h0;
    FIR_out24 = 24'h0;
    for (int i = 1; i >= 0; i--) exp16.push_back(8'((r16 >> (8 * i)) & 16'hFF));
    for (int i = 2; i >= 0; i--) exp24.push_back(8'((r24 >> (8 * i)) & 24'hFF));
  endtask

  task automatic wait_idle_and_compare();
    for (int i = 0; i < 3000 && (sbusy16 || sbusy24); i++) @(negedge clk);
    check_output("idle_reached", {31'b0, sbusy16 | sbusy24}, 32'd0);
    check_output("n_bytes16", got16.size(), exp16.size());
    check_output("n_bytes24", got24.size(), exp24.size());
    for (int i = 0; i < got16.size() && i < exp16.size(); i++)
      check_output($sformatf("byte16_%0d", i), {24'b0, got16[i]}, {24'b0, exp16[i]});
    for (int i = 0; i < got24.size() && i < exp24.size(); i++)
      check_output($sformatf("byte24_%0d", i), {24'b0, got24[i]}, {24'b0, exp24[i]});
    got16.delete(); got24.delete(); exp16.delete(); exp24.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_outs16"}, {8'b0, fin16, data16}, 32'd0);
    check_output({tag, "_outs24"}, {8'b0, fin24, data24}, 32'd0);
    check_output({tag, "_flags"},
                 {20'b0, start16, strt16, sbusy16, ovr16, tmo16, 1'b0,
                  start24, strt24, sbusy24, ovr24, tmo24, 1'b0}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] m, l;
    rst = 1'b1; RxD_ready = 1'b0; RxD_data = 8'h0;
    FIR_valid = 1'b0; FIR_out16 = 16'h0; FIR_out24 = 24'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed sample 0x1234, results 0xABCD / 0x0102A5");
    apply_stimulus(8'h12, 8'h34, 2);
    fir_reply(16'hABCD, 24'h0102A5, 3);
    wait_idle_and_compare();

    $display("[TB] FIR_valid while idle is ignored");
    FIR_out16 = 16'hFFFF; FIR_out24 = 24'hFFFFFF; FIR_valid = 1'b1;
    @(negedge clk);
    FIR_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_output("valid_idle_busy", {31'b0, sbusy16 | sbusy24}, 32'd0);
    check_output("valid_idle_bytes", got16.size() + got24.size(), 32'd0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      m = 8'($urandom);
      l = 8'($urandom);
      apply_stimulus(m, l, $urandom_range(0, 4));
      fir_reply(16'($urandom), 24'($urandom), $urandom_range(0, 6));
      wait_idle_and_compare();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_output("no_overrun_yet", {30'b0, ovr16, ovr24}, 32'd0);

    $display("[TB] byte during FIR wait is dropped");
    m = 8'($urandom); l = 8'($urandom);
    apply_stimulus(m, l, 1);
    repeat (2) @(negedge clk);
    rx_byte(8'h77);
    check_output("overrun_set", {30'b0, ovr16, ovr24}, 32'd3);
    check_output("sample_intact", {16'b0, fin16}, {16'b0, m, l});
    fir_reply(16'($urandom), 24'($urandom), 2);
    wait_idle_and_compare();
    check_output("overrun_sticky", {30'b0, ovr16, ovr24}, 32'd3);
    pulse_reset();
    check_output("overrun_cleared", {30'b0, ovr16, ovr24}, 32'd0);

    $display("[TB] byte on the drain-to-idle edge is dropped");
    apply_stimulus(8'hC3, 8'h3C, 0);
    fir_reply(16'h5AA5, 24'h123456, 0);
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(negedge clk);
      if (start16) n++;
    end
    check_output("two_starts_seen", n, 32'd2);
    repeat (BUSY_LEN + 1) @(negedge clk);
    RxD_data = 8'h99; RxD_ready = 1'b1;
    @(negedge clk);
    RxD_ready = 1'b0;
    check_output("exit_edge_idle", {31'b0, sbusy16}, 32'd0);
    check_output("exit_edge_overrun", {31'b0, ovr16}, 32'd1);
    wait_idle_and_compare();
    check_output("exit_edge_overrun24", {31'b0, ovr24}, 32'd1);
    pulse_reset();

    $display("[TB] reset during transmit drain");
    apply_stimulus(8'h01, 8'h02, 0);
    fir_reply(16'hE1F0, 24'hE1F0C3, 1);
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      @(negedge clk);
      if (start16) n = 1;
    end
    check_output("first_start_seen", n, 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_drain_reset");
    rst = 1'b0;
    got16.delete(); got24.delete(); exp16.delete(); exp24.delete();
    repeat (60) @(negedge clk);
    check_output("no_start_after_reset", got16.size() + got24.size(), 32'd0);
    check_output("idle_after_reset", {31'b0, sbusy16 | sbusy24}, 32'd0);

`ifdef RX_TIMEOUT_EN
    $display("[TB] inter-byte timeout");
    rx_byte(8'hAA);
    n = 0;
    while (!tmo16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout_latency", n, TMO);
    check_output("timeout_idle", {31'b0, sbusy16}, 32'd0);
    @(negedge clk);
    check_output("timeout_pulse_width", {31'b0, tmo16}, 32'd0);
    apply_stimulus(8'h55, 8'h66, 0);
    fir_reply(16'($urandom), 24'($urandom), 1);
    wait_idle_and_compare();
    apply_stimulus(8'h9A, 8'hBC, TMO - 1);
    fir_reply(16'($urandom), 24'($urandom), 1);
    wait_idle_and_compare();
`else
    $display("[TB] long inter-byte gap without timeout");
    rx_byte(8'h5A);
    repeat (200) @(negedge clk);
    check_output("long_gap_busy", {31'b0, sbusy16}, 32'd1);
    check_output("rx_timeout_tied", {30'b0, tmo16, tmo24}, 32'd0);
    rx_byte(8'hA5);
    check_output("long_gap_strt", {31'b0, strt16}, 32'd1);
    check_output("long_gap_fir_in", {16'b0, fin16}, 32'h5AA5);
    fir_reply(16'($urandom), 24'($urandom), 1);
    wait_idle_and_compare();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
